// File: rtl/dfx_axil_reg_responder.sv
// ----------------------------------------------------------------------------
// dfx_axil_reg_responder
// AXI4-Lite responder terminating the PCIe-to-DFX control path. Hosts a small
// register bank (ID, SCRATCH, CONTROL, STATUS, WRCOUNT), drives the CONTROL
// value to the MCU and samples the MCU status word every cycle.
//
// Ports
//   AxiBusClock, xAxiBusReset      clock, synchronous active-high reset
//   xPcieToDfx_AXI_aw*/w*/b*       AXI4-Lite write address/data/response
//   xPcieToDfx_AXI_ar*/r*          AXI4-Lite read address/data
//   sMcuInputControl               CONTROL register toward the MCU
//   sMcuOutputControl              MCU status input (registered into STATUS)
//   xControlWritePulse             one-cycle pulse with bvalid of an OKAY CONTROL write
// ----------------------------------------------------------------------------
module dfx_axil_reg_responder #(
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned REG_ADDR_BITS = 5,
   parameter logic [31:0] ID_VALUE      = 32'hDF10_0001,
   parameter logic [31:0] CONTROL_RESET = 32'h0000_0000
) (
   input  logic                  AxiBusClock,
   input  logic                  xAxiBusReset,
   input  logic [ADDR_WIDTH-1:0] xPcieToDfx_AXI_awaddr,
   input  logic [2:0]            xPcieToDfx_AXI_awprot,
   input  logic                  xPcieToDfx_AXI_awvalid,
   output logic                  xPcieToDfx_AXI_awready,
   input  logic [31:0]           xPcieToDfx_AXI_wdata,
   input  logic [3:0]            xPcieToDfx_AXI_wstrb,
   input  logic                  xPcieToDfx_AXI_wvalid,
   output logic                  xPcieToDfx_AXI_wready,
   output logic [1:0]            xPcieToDfx_AXI_bresp,
   output logic                  xPcieToDfx_AXI_bvalid,
   input  logic                  xPcieToDfx_AXI_bready,
   input  logic [ADDR_WIDTH-1:0] xPcieToDfx_AXI_araddr,
   input  logic [2:0]            xPcieToDfx_AXI_arprot,
   input  logic                  xPcieToDfx_AXI_arvalid,
   output logic                  xPcieToDfx_AXI_arready,
   output logic [31:0]           xPcieToDfx_AXI_rdata,
   output logic [1:0]            xPcieToDfx_AXI_rresp,
   output logic                  xPcieToDfx_AXI_rvalid,
   input  logic                  xPcieToDfx_AXI_rready,
   output logic [31:0]           sMcuInputControl,
   input  logic [31:0]           sMcuOutputControl,
   output logic                  xControlWritePulse
);

   localparam int unsigned IDX_W = REG_ADDR_BITS - 2;
   localparam logic [IDX_W-1:0] IDX_ID      = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_CONTROL = IDX_W'(2);
   localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(3);
   localparam logic [IDX_W-1:0] IDX_WRCOUNT = IDX_W'(4);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic W_IDLE = 1'b0;
   localparam logic W_RESP = 1'b1;
   localparam logic R_IDLE = 1'b0;
   localparam logic R_DATA = 1'b1;

   logic                  wState, wStateNext;
   logic                  rState, rStateNext;
   logic                  awHeld, wHeld;
   logic [ADDR_WIDTH-1:0] awAddrQ;
   logic [31:0]           wDataQ;
   logic [3:0]            wStrbQ;
   logic [31:0]           scratchQ, statusQ, wrCountQ;

   // Byte-lane merge of new write data into an existing register value
   function automatic logic [31:0] mergeStrobe(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = oldVal;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = newVal[b*8 +: 8];
      end
      return res;
   endfunction

   // Write side: AW/W may arrive in either order; a held beat takes priority over the bus
   logic                  awHs, wHs, haveAw, haveW, commit;
   logic [ADDR_WIDTH-1:0] wrAddr;
   logic [31:0]           wrData;
   logic [3:0]            wrStrb;
   logic                  wrHit, wrScratch, wrControl, wrOk;
   logic [IDX_W-1:0]      wrIdx;

   assign awHs      = xPcieToDfx_AXI_awvalid & xPcieToDfx_AXI_awready;
   assign wHs       = xPcieToDfx_AXI_wvalid & xPcieToDfx_AXI_wready;
   assign haveAw    = awHeld | awHs;
   assign haveW     = wHeld | wHs;
   assign commit    = (wState == W_IDLE) & haveAw & haveW;
   assign wrAddr    = awHeld ? awAddrQ : xPcieToDfx_AXI_awaddr;
   assign wrData    = wHeld ? wDataQ : xPcieToDfx_AXI_wdata;
   assign wrStrb    = wHeld ? wStrbQ : xPcieToDfx_AXI_wstrb;
   assign wrHit     = (wrAddr[ADDR_WIDTH-1:REG_ADDR_BITS] == '0);
   assign wrIdx     = wrAddr[REG_ADDR_BITS-1:2];
   assign wrScratch = wrHit & (wrIdx == IDX_SCRATCH);
   assign wrControl = wrHit & (wrIdx == IDX_CONTROL);
   assign wrOk      = wrScratch | wrControl;

   // Read side decode and data mux
   logic             arHs, rdHit, rdOk;
   logic [IDX_W-1:0] rdIdx;
   logic [31:0]      rdMux;

   assign arHs  = xPcieToDfx_AXI_arvalid & xPcieToDfx_AXI_arready;
   assign rdHit = (xPcieToDfx_AXI_araddr[ADDR_WIDTH-1:REG_ADDR_BITS] == '0);
   assign rdIdx = xPcieToDfx_AXI_araddr[REG_ADDR_BITS-1:2];

   always_comb begin
      rdMux = 32'h0;
      rdOk  = rdHit;
      case (rdIdx)
         IDX_ID:      rdMux = ID_VALUE;
         IDX_SCRATCH: rdMux = scratchQ;
         IDX_CONTROL: rdMux = sMcuInputControl;
         IDX_STATUS:  rdMux = statusQ;
         IDX_WRCOUNT: rdMux = wrCountQ;
         default:     rdOk  = 1'b0;
      endcase
      if (!rdOk) rdMux = 32'h0;
   end

   // Address LSBs and protection bits carry no meaning for this bank
   logic unusedBits;
   assign unusedBits = ^{xPcieToDfx_AXI_awprot, xPcieToDfx_AXI_arprot,
                         wrAddr[1:0], xPcieToDfx_AXI_araddr[1:0]};

   // Next-state logic for both channel FSMs
   always_comb begin
      wStateNext = wState;
      rStateNext = rState;
      case (wState)
         W_IDLE:  if (commit) wStateNext = W_RESP;
         W_RESP:  if (xPcieToDfx_AXI_bready) wStateNext = W_IDLE;
         default: wStateNext = W_IDLE;
      endcase
      case (rState)
         R_IDLE:  if (arHs) rStateNext = R_DATA;
         R_DATA:  if (xPcieToDfx_AXI_rready) rStateNext = R_IDLE;
         default: rStateNext = R_IDLE;
      endcase
   end

   // State, register bank and registered channel outputs
   always_ff @(posedge AxiBusClock) begin
      if (xAxiBusReset) begin
         wState                 <= W_IDLE;
         rState                 <= R_IDLE;
         awHeld                 <= 1'b0;
         wHeld                  <= 1'b0;
         awAddrQ                <= '0;
         wDataQ                 <= 32'h0;
         wStrbQ                 <= 4'h0;
         scratchQ               <= 32'h0;
         statusQ                <= 32'h0;
         wrCountQ               <= 32'h0;
         sMcuInputControl       <= CONTROL_RESET;
         xControlWritePulse     <= 1'b0;
         xPcieToDfx_AXI_awready <= 1'b0;
         xPcieToDfx_AXI_wready  <= 1'b0;
         xPcieToDfx_AXI_bvalid  <= 1'b0;
         xPcieToDfx_AXI_bresp   <= RESP_OKAY;
         xPcieToDfx_AXI_arready <= 1'b0;
         xPcieToDfx_AXI_rvalid  <= 1'b0;
         xPcieToDfx_AXI_rresp   <= RESP_OKAY;
         xPcieToDfx_AXI_rdata   <= 32'h0;
      end else begin
         wState             <= wStateNext;
         rState             <= rStateNext;
         statusQ            <= sMcuOutputControl;
         xControlWritePulse <= commit & wrControl;

         if (wState == W_IDLE) begin
            if (awHs) begin
               awAddrQ <= xPcieToDfx_AXI_awaddr;
               awHeld  <= 1'b1;
            end
            if (wHs) begin
               wDataQ <= xPcieToDfx_AXI_wdata;
               wStrbQ <= xPcieToDfx_AXI_wstrb;
               wHeld  <= 1'b1;
            end
            xPcieToDfx_AXI_awready <= ~haveAw;
            xPcieToDfx_AXI_wready  <= ~haveW;
            if (commit) begin
               awHeld                <= 1'b0;
               wHeld                 <= 1'b0;
               xPcieToDfx_AXI_bvalid <= 1'b1;
               xPcieToDfx_AXI_bresp  <= wrOk ? RESP_OKAY : RESP_SLVERR;
               if (wrScratch) scratchQ <= mergeStrobe(scratchQ, wrData, wrStrb);
               if (wrControl) sMcuInputControl <= mergeStrobe(sMcuInputControl, wrData, wrStrb);
               if (wrOk) wrCountQ <= wrCountQ + 32'd1;
            end
         end else if (xPcieToDfx_AXI_bready) begin
            xPcieToDfx_AXI_bvalid  <= 1'b0;
            xPcieToDfx_AXI_awready <= 1'b1;
            xPcieToDfx_AXI_wready  <= 1'b1;
         end

         if (rState == R_IDLE) begin
            if (arHs) begin
               xPcieToDfx_AXI_arready <= 1'b0;
               xPcieToDfx_AXI_rvalid  <= 1'b1;
               xPcieToDfx_AXI_rdata   <= rdMux;
               xPcieToDfx_AXI_rresp   <= rdOk ? RESP_OKAY : RESP_SLVERR;
            end else begin
               xPcieToDfx_AXI_arready <= 1'b1;
            end
         end else if (xPcieToDfx_AXI_rready) begin
            xPcieToDfx_AXI_rvalid  <= 1'b0;
            xPcieToDfx_AXI_arready <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dfx_axil_reg_responder.sv
// ----------------------------------------------------------------------------
// tb_dfx_axil_reg_responder
// Self-checking bench: directed vector table, hand-written corner sequences
// (B back-pressure, same-edge read/write, reset mid-read) and a random phase
// checked against a behavioural register-map model.
// ----------------------------------------------------------------------------
module tb_dfx_axil_reg_responder;

   localparam logic [31:0] ID_VAL = 32'hDF10_0001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [31:0] araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] ctrlOut;
   logic [31:0] statusIn = 32'hCAFE_0001;
   logic        ctrlPulse;

   int total = 0;
   int bad   = 0;
   int pulseCount = 0;

   // Behavioural model of the register map
   logic [31:0] mScratch = 0, mCtrl = 0, mCount = 0;
   int          mPulses = 0;

   dfx_axil_reg_responder dut (
      .AxiBusClock(clk), .xAxiBusReset(rst),
      .xPcieToDfx_AXI_awaddr(awaddr), .xPcieToDfx_AXI_awprot(awprot),
      .xPcieToDfx_AXI_awvalid(awvalid), .xPcieToDfx_AXI_awready(awready),
      .xPcieToDfx_AXI_wdata(wdata), .xPcieToDfx_AXI_wstrb(wstrb),
      .xPcieToDfx_AXI_wvalid(wvalid), .xPcieToDfx_AXI_wready(wready),
      .xPcieToDfx_AXI_bresp(bresp), .xPcieToDfx_AXI_bvalid(bvalid),
      .xPcieToDfx_AXI_bready(bready),
      .xPcieToDfx_AXI_araddr(araddr), .xPcieToDfx_AXI_arprot(arprot),
      .xPcieToDfx_AXI_arvalid(arvalid), .xPcieToDfx_AXI_arready(arready),
      .xPcieToDfx_AXI_rdata(rdata), .xPcieToDfx_AXI_rresp(rresp),
      .xPcieToDfx_AXI_rvalid(rvalid), .xPcieToDfx_AXI_rready(rready),
      .sMcuInputControl(ctrlOut), .sMcuOutputControl(statusIn),
      .xControlWritePulse(ctrlPulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeoutFail(input string name);
      total++;
      bad++;
      $display("FAIL %s: timeout waiting for handshake at %0t", name, $time);
   endtask

   // Pulse must coincide with a write response
   always @(negedge clk) begin
      if (ctrlPulse) begin
         pulseCount++;
         check("pulse_with_bvalid", 32'(bvalid), 32'd1);
      end
   end

   task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
      int idx;
      idx = int'((addr >> 2) & 32'd7);
      if ((addr >> 5) == 0 && (idx == 1 || idx == 2)) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
               if (idx == 1) mScratch[b*8 +: 8] = data[b*8 +: 8];
               else          mCtrl[b*8 +: 8]    = data[b*8 +: 8];
            end
         end
         mCount = mCount + 1;
         if (idx == 2) mPulses++;
         resp = 2'b00;
      end else begin
         resp = 2'b10;
      end
   endtask

   task automatic modelRead(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
      int idx;
      idx  = int'((addr >> 2) & 32'd7);
      data = 0;
      resp = 2'b00;
      if ((addr >> 5) != 0 || idx > 4) resp = 2'b10;
      else if (idx == 0) data = ID_VAL;
      else if (idx == 1) data = mScratch;
      else if (idx == 2) data = mCtrl;
      else if (idx == 3) data = statusIn;
      else               data = mCount;
   endtask

   task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int awDly, input int wDly,
                           input int bDly, output logic [1:0] resp);
      bit awDone = 0, wDone = 0, awHs, wHs;
      int cyc = 0;
      bready = 1'b0;
      while (!(awDone && wDone)) begin
         if (cyc > 100) begin
            timeoutFail("aw_w_accept");
            break;
         end
         @(negedge clk);
         if (wDone && !awDone) check("wready_low_after_w", 32'(wready), 32'd0);
         if (awDone && !wDone) check("awready_low_after_aw", 32'(awready), 32'd0);
         awaddr  = addr;
         wdata   = data;
         wstrb   = strb;
         awvalid = !awDone && cyc >= awDly;
         wvalid  = !wDone && cyc >= wDly;
         awHs    = awvalid && awready;
         wHs     = wvalid && wready;
         @(posedge clk);
         awDone |= awHs;
         wDone  |= wHs;
         cyc++;
      end
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      check("bvalid_latency", 32'(bvalid), 32'd1);
      cyc = 0;
      while (!bvalid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (!bvalid) timeoutFail("bvalid_wait");
      resp = bresp;
      repeat (bDly) @(negedge clk);
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bready = 1'b0;
      check("bvalid_drop", 32'(bvalid), 32'd0);
      check("awready_restored", 32'(awready), 32'd1);
   endtask

   task automatic axiRead(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
      int cyc = 0;
      @(negedge clk);
      araddr  = addr;
      arvalid = 1'b1;
      while (!arready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (!arready) timeoutFail("arready_wait");
      @(posedge clk);
      @(negedge clk);
      arvalid = 1'b0;
      check("rvalid_latency", 32'(rvalid), 32'd1);
      check("arready_busy", 32'(arready), 32'd0);
      data   = rdata;
      resp   = rresp;
      rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rready = 1'b0;
      check("rvalid_drop", 32'(rvalid), 32'd0);
      check("arready_restored", 32'(arready), 32'd1);
   endtask

   typedef struct {
      bit          isWr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          awDly;
      int          wDly;
      logic [1:0]  expResp;
      logic [31:0] expData;
      logic [31:0] expCtrl;
   } vec_t;

   vec_t tbl[24];

   initial begin
      logic [31:0] d, md;
      logic [1:0]  r, mr;

      tbl[0]  = '{0, 32'h00, 0, 0, 0, 0, 2'b00, 32'hDF10_0001, 32'h0};
      tbl[1]  = '{1, 32'h08, 32'hA5A5_1234, 4'b0101, 3, 0, 2'b00, 0, 32'h00A5_0034};
      tbl[2]  = '{0, 32'h08, 0, 0, 0, 0, 2'b00, 32'h00A5_0034, 32'h00A5_0034};
      tbl[3]  = '{0, 32'h10, 0, 0, 0, 0, 2'b00, 32'h1, 32'h00A5_0034};
      tbl[4]  = '{1, 32'h0C, 32'h1234_5678, 4'hF, 0, 1, 2'b10, 0, 32'h00A5_0034};
      tbl[5]  = '{0, 32'h0C, 0, 0, 0, 0, 2'b00, 32'hCAFE_0001, 32'h00A5_0034};
      tbl[6]  = '{0, 32'h18, 0, 0, 0, 0, 2'b10, 32'h0, 32'h00A5_0034};
      tbl[7]  = '{0, 32'h10, 0, 0, 0, 0, 2'b00, 32'h1, 32'h00A5_0034};
      tbl[8]  = '{1, 32'h04, 32'h1111_1111, 4'hF, 0, 0, 2'b00, 0, 32'h00A5_0034};
      tbl[9]  = '{0, 32'h04, 0, 0, 0, 0, 2'b00, 32'h1111_1111, 32'h00A5_0034};
      tbl[10] = '{1, 32'h06, 32'hFFFF_FFFF, 4'h0, 1, 2, 2'b00, 0, 32'h00A5_0034};
      tbl[11] = '{0, 32'h04, 0, 0, 0, 0, 2'b00, 32'h1111_1111, 32'h00A5_0034};
      tbl[12] = '{0, 32'h10, 0, 0, 0, 0, 2'b00, 32'h3, 32'h00A5_0034};
      tbl[13] = '{1, 32'h00, 32'h0BAD_0BAD, 4'hF, 0, 0, 2'b10, 0, 32'h00A5_0034};
      tbl[14] = '{1, 32'h24, 32'h0BAD_0BAD, 4'hF, 2, 0, 2'b10, 0, 32'h00A5_0034};
      tbl[15] = '{0, 32'h24, 0, 0, 0, 0, 2'b10, 32'h0, 32'h00A5_0034};
      tbl[16] = '{0, 32'h8000_0004, 0, 0, 0, 0, 2'b10, 32'h0, 32'h00A5_0034};
      tbl[17] = '{0, 32'h14, 0, 0, 0, 0, 2'b10, 32'h0, 32'h00A5_0034};
      tbl[18] = '{1, 32'h09, 32'hDEAD_BEEF, 4'b1000, 2, 2, 2'b00, 0, 32'hDEA5_0034};
      tbl[19] = '{0, 32'h0B, 0, 0, 0, 0, 2'b00, 32'hDEA5_0034, 32'hDEA5_0034};
      tbl[20] = '{0, 32'h10, 0, 0, 0, 0, 2'b00, 32'h4, 32'hDEA5_0034};
      tbl[21] = '{0, 32'h1C, 0, 0, 0, 0, 2'b10, 32'h0, 32'hDEA5_0034};
      tbl[22] = '{0, 32'h0E, 0, 0, 0, 0, 2'b00, 32'hCAFE_0001, 32'hDEA5_0034};
      tbl[23] = '{0, 32'h01, 0, 0, 0, 0, 2'b00, 32'hDF10_0001, 32'hDEA5_0034};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_bvalid", 32'(bvalid), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_ctrl", ctrlOut, 32'h0);
      check("rst_pulse", 32'(ctrlPulse), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post_rst_awready", 32'(awready), 32'd1);
      check("post_rst_wready", 32'(wready), 32'd1);
      check("post_rst_arready", 32'(arready), 32'd1);

      // Directed vector table
      for (int i = 0; i < 24; i++) begin
         if (tbl[i].isWr) begin
            axiWrite(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].awDly, tbl[i].wDly, 0, r);
            modelWrite(tbl[i].addr, tbl[i].data, tbl[i].strb, mr);
            check($sformatf("tbl%0d_bresp", i), 32'(r), 32'(tbl[i].expResp));
         end else begin
            axiRead(tbl[i].addr, d, r);
            check($sformatf("tbl%0d_rresp", i), 32'(r), 32'(tbl[i].expResp));
            check($sformatf("tbl%0d_rdata", i), d, tbl[i].expData);
         end
         check($sformatf("tbl%0d_ctrl", i), ctrlOut, tbl[i].expCtrl);
      end
      check("tbl_pulse_count", 32'(pulseCount), 32'd2);

      // B back-pressure: bready low for 10 cycles, a new AW must wait
      @(negedge clk);
      awaddr = 32'h04; wdata = 32'h5555_AAAA; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      modelWrite(32'h04, 32'h5555_AAAA, 4'hF, mr);
      for (int k = 0; k < 10; k++) begin
         awaddr = 32'h08; awvalid = 1'b1;
         check("hold_bvalid", 32'(bvalid), 32'd1);
         check("hold_bresp", 32'(bresp), 32'd0);
         check("hold_awready", 32'(awready), 32'd0);
         check("hold_wready", 32'(wready), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      awvalid = 1'b0;
      bready  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bready = 1'b0;
      check("hold_bvalid_drop", 32'(bvalid), 32'd0);
      check("hold_awready_back", 32'(awready), 32'd1);
      check("hold_wready_back", 32'(wready), 32'd1);
      axiRead(32'h04, d, r);
      check("hold_scratch", d, 32'h5555_AAAA);

      // Same-edge read and write commit to SCRATCH returns the old value
      axiWrite(32'h04, 32'h1111_1111, 4'hF, 0, 0, 0, r);
      modelWrite(32'h04, 32'h1111_1111, 4'hF, mr);
      @(negedge clk);
      araddr = 32'h04; arvalid = 1'b1;
      awaddr = 32'h04; awvalid = 1'b1;
      wdata = 32'h2222_2222; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      modelWrite(32'h04, 32'h2222_2222, 4'hF, mr);
      check("same_edge_rvalid", 32'(rvalid), 32'd1);
      check("same_edge_rdata", rdata, 32'h1111_1111);
      check("same_edge_bvalid", 32'(bvalid), 32'd1);
      rready = 1'b1; bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rready = 1'b0; bready = 1'b0;
      axiRead(32'h04, d, r);
      check("same_edge_followup", d, 32'h2222_2222);

      // Reset while rvalid is pending
      axiWrite(32'h08, 32'h0F0F_0F0F, 4'hF, 0, 0, 0, r);
      modelWrite(32'h08, 32'h0F0F_0F0F, 4'hF, mr);
      @(negedge clk);
      araddr = 32'h10; arvalid = 1'b1; rready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      arvalid = 1'b0;
      check("midrst_rvalid_before", 32'(rvalid), 32'd1);
      check("midrst_rdata_before", rdata, mCount);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_rvalid", 32'(rvalid), 32'd0);
      check("midrst_rdata", rdata, 32'h0);
      check("midrst_ctrl", ctrlOut, 32'h0);
      check("midrst_arready", 32'(arready), 32'd0);
      rst = 1'b0;
      mScratch = 0; mCtrl = 0; mCount = 0;
      axiRead(32'h10, d, r);
      check("midrst_wrcount", d, 32'h0);
      axiRead(32'h04, d, r);
      check("midrst_scratch", d, 32'h0);

      // Random traffic against the model
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a, wd;
         logic [3:0]  s;
         a = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(5, 31));
         if ($urandom_range(0, 9) == 0) begin
            @(negedge clk);
            statusIn = $urandom;
            repeat (2) @(posedge clk);
         end
         if ($urandom_range(0, 1) == 1) begin
            wd = $urandom;
            s  = 4'($urandom_range(0, 15));
            axiWrite(a, wd, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), r);
            modelWrite(a, wd, s, mr);
            check($sformatf("rnd%0d_bresp_a%h", n, a), 32'(r), 32'(mr));
            check($sformatf("rnd%0d_ctrl", n), ctrlOut, mCtrl);
         end else begin
            axiRead(a, d, r);
            modelRead(a, md, mr);
            check($sformatf("rnd%0d_rresp_a%h", n, a), 32'(r), 32'(mr));
            check($sformatf("rnd%0d_rdata_a%h", n, a), d, md);
         end
      end
      axiRead(32'h10, d, r);
      check("final_wrcount", d, mCount);
      @(negedge clk);
      check("final_pulse_count", 32'(pulseCount), 32'(mPulses));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the bench always terminates
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/dfx_axil_reg_responder.md
Name: dfx_axil_reg_responder

Overview:
- AXI4-Lite responder (slave) for the PCIe-to-DFX control path; terminates the xPcieToDfx_AXI master interface.
- Implements a small register bank: ID, scratch, MCU input control, MCU output status and a write counter.
- Drives sMcuInputControl toward the MCU and samples sMcuOutputControl back.
- Sits inside the DFX main top, on AxiBusClock.

Parameters:
- ADDR_WIDTH, 32, width of the araddr/awaddr ports.
- REG_ADDR_BITS, 5, decoded byte-address window (32 B); address bits above it must be zero for a hit.
- ID_VALUE, 32'hDF10_0001, read-only value at offset 0x00.
- CONTROL_RESET, 32'h0000_0000, reset value of the CONTROL register.

Ports:
- AxiBusClock  in  1  sole clock; all logic on rising edge.
- xAxiBusReset  in  1  synchronous, active-high reset.
- xPcieToDfx_AXI_awaddr  in  ADDR_WIDTH  write address.
- xPcieToDfx_AXI_awprot  in  3  ignored.
- xPcieToDfx_AXI_awvalid / _awready  in/out  1  write-address handshake.
- xPcieToDfx_AXI_wdata  in  32  write data.
- xPcieToDfx_AXI_wstrb  in  4  byte enables.
- xPcieToDfx_AXI_wvalid / _wready  in/out  1  write-data handshake.
- xPcieToDfx_AXI_bresp  out  2  write response.
- xPcieToDfx_AXI_bvalid / _bready  out/in  1  write-response handshake.
- xPcieToDfx_AXI_araddr  in  ADDR_WIDTH  read address.
- xPcieToDfx_AXI_arprot  in  3  ignored.
- xPcieToDfx_AXI_arvalid / _arready  in/out  1  read-address handshake.
- xPcieToDfx_AXI_rdata  out  32  read data.
- xPcieToDfx_AXI_rresp  out  2  read response.
- xPcieToDfx_AXI_rvalid / _rready  out/in  1  read-data handshake.
- sMcuInputControl  out  32  registered CONTROL register value.
- sMcuOutputControl  in  32  MCU status, sampled every cycle.
- xControlWritePulse  out  1  one-cycle pulse after any write to CONTROL.

Behaviour:
- Interface decided: one clock AxiBusClock; reset xAxiBusReset is synchronous and active-high.
- All outputs registered.
- Reset values:
  - all ready, bvalid and rvalid = 0; bresp = rresp = 0; rdata = 0.
  - sMcuInputControl = CONTROL_RESET; SCRATCH = 0; WRCOUNT = 0; status sample = 0; xControlWritePulse = 0.
  - First cycle after reset deasserts: awready = wready = arready = 1.
- Register map (addr[1:0] ignored):
  - 0x00 ID: RO, ID_VALUE.
  - 0x04 SCRATCH: RW, byte-strobed.
  - 0x08 CONTROL: RW, byte-strobed; drives sMcuInputControl.
  - 0x0C STATUS: RO, sMcuOutputControl registered one cycle.
  - 0x10 WRCOUNT: RO, count of OKAY writes, wraps 0xFFFFFFFF->0.
  - Offsets 0x14-0x1F, or any nonzero bit above REG_ADDR_BITS: unmapped.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: AW and W accepted independently, in either order or the same cycle. awready drops after AW is captured; wready drops after W is captured.
  - Once both are held, the register update occurs on that edge and the FSM enters W_RESP with bvalid=1 on the next cycle.
  - Write to a RO or unmapped address: no state change, bresp=SLVERR (2'b10). Otherwise bresp=OKAY and WRCOUNT increments.
  - wstrb=0 to a RW register: OKAY, data unchanged, WRCOUNT still increments.
  - W_RESP: bvalid and bresp held until bready. On the bvalid&bready edge: bvalid=0, awready=wready=1, return to W_IDLE.
  - Only one write outstanding at a time.
  - xControlWritePulse is asserted in the cycle bvalid first rises, only for an OKAY CONTROL write.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1. On arvalid&arready, capture the address; next cycle rvalid=1 with rdata/rresp (latency 1). arready=0 while in R_DATA.
  - Unmapped read: rdata=0, rresp=SLVERR.
  - rdata and rresp held stable until rready. On the rvalid&rready edge: rvalid=0, arready=1.
- Read and write paths are fully independent. A read sampled on the same edge as a write commit to the same register returns the pre-write value.
- Reset asserted mid-transaction: the transaction is abandoned and every output holds its reset value from the next edge. No partial write completes unless the commit edge preceded reset.

Test Plan:
- Reset, then read 0x00 -> rvalid one cycle after the AR handshake, rdata=32'hDF100001, rresp=2'b00; arready=0 while rvalid is high.
- W before AW (W at cycle 0, AW at cycle 3) to 0x08, data 0xA5A5_1234, wstrb 4'b0101 -> sMcuInputControl=0x00A5_0034; bvalid with OKAY; one xControlWritePulse; WRCOUNT reads 1.
- Write to 0x0C and read 0x18 -> bresp=SLVERR with STATUS unchanged; rresp=SLVERR with rdata=0; WRCOUNT unchanged.
- Hold bready low 10 cycles after a write to 0x04 -> bvalid and bresp stable; awready=wready=0 throughout; a new AW is not accepted until the B handshake.
- Simultaneous AR and AW/W to 0x04 (old 0x1111_1111, new 0x2222_2222) -> read returns 0x1111_1111; a following read returns 0x2222_2222.
- Assert reset while rvalid=1 and rready=0 -> next edge rvalid=0, rdata=0, sMcuInputControl=CONTROL_RESET, WRCOUNT=0.
